// File: rtl/ysyx_23060201_pkg.sv
// Shared LSU types: FSM states, funct3 encodings, timeout length
// and the access-legality check used at request accept.
package ysyx_23060201_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_RESP
  } lsu_state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam int unsigned LSU_TIMEOUT_CYCLES = 255;

  function automatic logic lsu_illegal(
    input logic       ren,
    input logic       wen,
    input logic [2:0] f3,
    input logic [1:0] off
  );
    logic ill;
    ill = 1'b0;
    if (ren && wen) begin
      ill = 1'b1;
    end else if (ren) begin
      case (f3)
        F3_LB, F3_LBU: ill = 1'b0;
        F3_LH, F3_LHU: ill = off[0];
        F3_LW:         ill = |off;
        default:       ill = 1'b1;
      endcase
    end else if (wen) begin
      case (f3)
        F3_SB:   ill = 1'b0;
        F3_SH:   ill = off[0];
        F3_SW:   ill = |off;
        default: ill = 1'b1;
      endcase
    end
    return ill;
  endfunction

endpackage

// File: rtl/ysyx_23060201_lsu_align.sv
// Byte-lane steering: store shift/mask and load extract/extend.
module ysyx_23060201_lsu_align
  import ysyx_23060201_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [2:0]            funct3_i,
  input  logic [1:0]            off_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  output logic [DATA_WIDTH-1:0] st_wdata_o,
  output logic [7:0]            st_wmask_o,
  output logic [DATA_WIDTH-1:0] ld_data_o
);

  logic [4:0]            shamt;
  logic [DATA_WIDTH-1:0] ld_sh;

  assign shamt      = {off_i, 3'b000};
  assign st_wdata_o = wdata_i << shamt;
  assign ld_sh      = rdata_i >> shamt;

  always_comb begin
    st_wmask_o = 8'h00;
    case (funct3_i)
      F3_SB:   st_wmask_o = {4'h0, 4'b0001 << off_i};
      F3_SH:   st_wmask_o = {4'h0, 4'b0011 << off_i};
      default: st_wmask_o = 8'h0F;
    endcase
  end

  always_comb begin
    ld_data_o = ld_sh;
    case (funct3_i)
      F3_LB:   ld_data_o = {{(DATA_WIDTH-8){ld_sh[7]}}, ld_sh[7:0]};
      F3_LH:   ld_data_o = {{(DATA_WIDTH-16){ld_sh[15]}}, ld_sh[15:0]};
      F3_LBU:  ld_data_o = {{(DATA_WIDTH-8){1'b0}}, ld_sh[7:0]};
      F3_LHU:  ld_data_o = {{(DATA_WIDTH-16){1'b0}}, ld_sh[15:0]};
      default: ld_data_o = ld_sh;
    endcase
  end

endmodule

// File: rtl/ysyx_23060201_lsu.sv
// Single-outstanding load/store unit with a 4-state request FSM.
// Optional WAIT timeout: define YSYX_23060201_LSU_TIMEOUT_EN.
module ysyx_23060201_lsu
  import ysyx_23060201_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_ren,
  input  logic                  in_wen,
  input  logic [2:0]            in_funct3,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  input  logic [DATA_WIDTH-1:0] in_wdata,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [7:0]            mem_wmask,
  input  logic                  mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] mem_rsp_rdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_rdata,
  output logic                  out_err
);

  lsu_state_e            state_q, state_d;
  logic                  ren_q, ren_d;
  logic                  wen_q, wen_d;
  logic [2:0]            f3_q, f3_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] st_wdata, ld_data;
  logic [7:0]            st_wmask;
  logic                  in_req;
`ifdef YSYX_23060201_LSU_TIMEOUT_EN
  logic [7:0]            cnt_q, cnt_d;
`endif

  ysyx_23060201_lsu_align #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_align (
    .funct3_i   (f3_q),
    .off_i      (addr_q[1:0]),
    .wdata_i    (wdata_q),
    .rdata_i    (mem_rsp_rdata),
    .st_wdata_o (st_wdata),
    .st_wmask_o (st_wmask),
    .ld_data_o  (ld_data)
  );

  always_comb begin
    logic ill;
    ill     = 1'b0;
    state_d = state_q;
    ren_d   = ren_q;
    wen_d   = wen_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
`ifdef YSYX_23060201_LSU_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          ren_d   = in_ren;
          wen_d   = in_wen;
          f3_d    = in_funct3;
          addr_d  = in_addr;
          wdata_d = in_wdata;
          ill = lsu_illegal(in_ren, in_wen,
                            in_funct3, in_addr[1:0]);
          if (ill || !(in_ren || in_wen)) begin
            state_d = S_RESP;
            rdata_d = '0;
            err_d   = ill;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        state_d = S_WAIT;
`ifdef YSYX_23060201_LSU_TIMEOUT_EN
        cnt_d   = 8'd0;
`endif
      end
      S_WAIT: begin
        if (mem_rsp_valid) begin
          state_d = S_RESP;
          rdata_d = ren_q ? ld_data : '0;
          err_d   = 1'b0;
        end
`ifdef YSYX_23060201_LSU_TIMEOUT_EN
        else if (cnt_q == 8'(LSU_TIMEOUT_CYCLES - 1)) begin
          state_d = S_RESP;
          rdata_d = '0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end
      S_RESP: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ren_q   <= 1'b0;
      wen_q   <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
`ifdef YSYX_23060201_LSU_TIMEOUT_EN
      cnt_q   <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      ren_q   <= ren_d;
      wen_q   <= wen_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
`ifdef YSYX_23060201_LSU_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  // All memory-side outputs are gated so they read 0 outside REQ.
  assign in_req    = (state_q == S_REQ);
  assign in_ready  = (state_q == S_IDLE);
  assign mem_req   = in_req;
  assign mem_we    = in_req & wen_q;
  assign mem_addr  = in_req ? {addr_q[ADDR_WIDTH-1:2], 2'b00} : '0;
  assign mem_wdata = in_req ? st_wdata : '0;
  assign mem_wmask = (in_req && wen_q) ? st_wmask : 8'h00;
  assign out_valid = (state_q == S_RESP);
  assign out_rdata = out_valid ? rdata_q : '0;
  assign out_err   = out_valid & err_q;

endmodule

// File: tb/tb_ysyx_23060201_lsu.sv
// Directed self-checking bench for ysyx_23060201_lsu.
module tb_ysyx_23060201_lsu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_ren = 1'b0;
  logic        in_wen = 1'b0;
  logic [2:0]  in_funct3 = 3'b000;
  logic [31:0] in_addr = '0;
  logic [31:0] in_wdata = '0;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_rdata = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_rdata;
  logic        out_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ysyx_23060201_lsu dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_ren        (in_ren),
    .in_wen        (in_wen),
    .in_funct3     (in_funct3),
    .in_addr       (in_addr),
    .in_wdata      (in_wdata),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_wmask     (mem_wmask),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_rdata (mem_rsp_rdata),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_rdata     (out_rdata),
    .out_err       (out_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic w,
                       input logic [2:0] f3,
                       input logic [31:0] a,
                       input logic [31:0] d);
    in_valid  = 1'b1;
    in_ren    = r;
    in_wen    = w;
    in_funct3 = f3;
    in_addr   = a;
    in_wdata  = d;
  endtask

  task automatic issue(input logic r, input logic w,
                       input logic [2:0] f3,
                       input logic [31:0] a,
                       input logic [31:0] d);
    drive(r, w, f3, a, d);
    step();
    in_valid = 1'b0;
  endtask

  task automatic respond(input logic [31:0] d);
    mem_rsp_valid = 1'b1;
    mem_rsp_rdata = d;
    step();
    mem_rsp_valid = 1'b0;
  endtask

  task automatic release_resp();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [103:0] outs;
    rst_n = 1'b0;
    step();
    step();
    outs = {mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
            out_valid, out_rdata, out_err};
    checks++;
    if (outs !== '0) begin
      errors++;
      $display("FAIL reset_outs got %h exp 0", outs);
    end
    rst_n = 1'b1;
    step();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got %b exp 1", in_ready);
    end
  endtask

  task automatic test_store_byte();
    issue(1'b0, 1'b1, 3'b000, 32'h8000_0003, 32'h0000_00AB);
    checks++;
    if ({mem_req, mem_we} !== 2'b11) begin
      errors++;
      $display("FAIL sb_req got %b exp 11", {mem_req, mem_we});
    end
    checks++;
    if (mem_addr !== 32'h8000_0000) begin
      errors++;
      $display("FAIL sb_addr got %h exp 80000000", mem_addr);
    end
    checks++;
    if (mem_wdata !== 32'hAB00_0000) begin
      errors++;
      $display("FAIL sb_wdata got %h exp ab000000", mem_wdata);
    end
    checks++;
    if (mem_wmask !== 8'h08) begin
      errors++;
      $display("FAIL sb_wmask got %h exp 08", mem_wmask);
    end
    step();
    checks++;
    if ({mem_req, mem_we, mem_wmask} !== 10'h0) begin
      errors++;
      $display("FAIL sb_wait_req got %b exp 0", mem_req);
    end
    respond(32'hDEAD_BEEF);
    checks++;
    if ({out_valid, out_err, out_rdata} !== {2'b10, 32'h0}) begin
      errors++;
      $display("FAIL sb_out got v%b e%b d%h exp v1 e0 d0",
               out_valid, out_err, out_rdata);
    end
    release_resp();
    checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      errors++;
      $display("FAIL sb_idle got %b exp 10", {in_ready, out_valid});
    end
  endtask

  task automatic test_load_extend();
    logic [2:0]  f3 [6] = '{3'b001, 3'b101, 3'b000,
                            3'b100, 3'b010, 3'b001};
    logic [31:0] ad [6] = '{32'h8000_0002, 32'h8000_0002,
                            32'h8000_0001, 32'h8000_0003,
                            32'h8000_0004, 32'h8000_0000};
    logic [31:0] rs [6] = '{32'h8001_1234, 32'h8001_1234,
                            32'h1234_8056, 32'hF000_0000,
                            32'hCAFE_BABE, 32'h0000_7FFF};
    logic [31:0] ex [6] = '{32'hFFFF_8001, 32'h0000_8001,
                            32'hFFFF_FF80, 32'h0000_00F0,
                            32'hCAFE_BABE, 32'h0000_7FFF};
    for (int i = 0; i < 6; i++) begin
      issue(1'b1, 1'b0, f3[i], ad[i], 32'h5555_5555);
      checks++;
      if ({mem_req, mem_we, mem_addr} !==
          {2'b10, ad[i] & 32'hFFFF_FFFC}) begin
        errors++;
        $display("FAIL ld_req[%0d] got %b%b %h exp 10 %h", i,
                 mem_req, mem_we, mem_addr, ad[i] & 32'hFFFF_FFFC);
      end
      step();
      respond(rs[i]);
      checks++;
      if ({out_valid, out_err} !== 2'b10) begin
        errors++;
        $display("FAIL ld_flags[%0d] got %b exp 10", i,
                 {out_valid, out_err});
      end
      checks++;
      if (out_rdata !== ex[i]) begin
        errors++;
        $display("FAIL ld_rdata[%0d] got %h exp %h", i,
                 out_rdata, ex[i]);
      end
      release_resp();
    end
  endtask

  task automatic test_errors();
    logic        r  [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic        w  [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [2:0]  f3 [6] = '{3'b010, 3'b001, 3'b010,
                            3'b011, 3'b100, 3'b010};
    logic [31:0] ad [6] = '{32'h8000_0006, 32'h8000_0001,
                            32'h8000_0000, 32'h8000_0000,
                            32'h8000_0000, 32'h8000_0000};
    logic        ee [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 6; i++) begin
      issue(r[i], w[i], f3[i], ad[i], 32'hFFFF_FFFF);
      checks++;
      if (mem_req !== 1'b0) begin
        errors++;
        $display("FAIL err_memreq[%0d] got %b exp 0", i, mem_req);
      end
      checks++;
      if ({out_valid, out_err} !== {1'b1, ee[i]}) begin
        errors++;
        $display("FAIL err_flags[%0d] got %b exp 1%b", i,
                 {out_valid, out_err}, ee[i]);
      end
      checks++;
      if (out_rdata !== 32'h0) begin
        errors++;
        $display("FAIL err_rdata[%0d] got %h exp 0", i, out_rdata);
      end
      release_resp();
    end
  endtask

  task automatic test_backpressure();
    issue(1'b1, 1'b0, 3'b010, 32'h8000_0008, 32'h0);
    step();
    respond(32'h1122_3344);
    drive(1'b0, 1'b1, 3'b000, 32'h8000_0000, 32'h77);
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if ({out_valid, in_ready, mem_req, out_rdata} !==
          {3'b100, 32'h1122_3344}) begin
        errors++;
        $display("FAIL bp_hold[%0d] got v%b r%b q%b d%h exp 1 0 0 %h",
                 i, out_valid, in_ready, mem_req, out_rdata,
                 32'h1122_3344);
      end
    end
    out_ready = 1'b1;
    step();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      errors++;
      $display("FAIL bp_release got %b exp 10", {in_ready, out_valid});
    end
    step();
    checks++;
    if ({in_ready, mem_req, out_valid} !== 3'b100) begin
      errors++;
      $display("FAIL bp_noaccept got %b exp 100",
               {in_ready, mem_req, out_valid});
    end
  endtask

  task automatic test_rsp_ignored();
    mem_rsp_valid = 1'b1;
    mem_rsp_rdata = 32'hBAD0_BAD0;
    step();
    step();
    checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      errors++;
      $display("FAIL ign_idle got %b exp 10", {in_ready, out_valid});
    end
    issue(1'b1, 1'b0, 3'b010, 32'h8000_000C, 32'h0);
    step();
    mem_rsp_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL ign_reqcycle got %b exp 0", out_valid);
    end
    step();
    checks++;
    if ({out_valid, in_ready} !== 2'b00) begin
      errors++;
      $display("FAIL ign_wait got %b exp 00", {out_valid, in_ready});
    end
    respond(32'h5A5A_5A5A);
    checks++;
    if ({out_valid, out_rdata} !== {1'b1, 32'h5A5A_5A5A}) begin
      errors++;
      $display("FAIL ign_rdata got %b %h exp 1 5a5a5a5a",
               out_valid, out_rdata);
    end
    release_resp();
  endtask

  task automatic test_back_to_back();
    issue(1'b0, 1'b1, 3'b001, 32'h8000_0002, 32'h0000_BEEF);
    checks++;
    if ({mem_we, mem_wdata, mem_wmask} !==
        {1'b1, 32'hBEEF_0000, 8'h0C}) begin
      errors++;
      $display("FAIL b2b_sh got %b %h %h exp 1 beef0000 0c",
               mem_we, mem_wdata, mem_wmask);
    end
    step();
    respond(32'hFFFF_FFFF);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    issue(1'b0, 1'b1, 3'b010, 32'h8000_0010, 32'h0102_0304);
    checks++;
    if ({mem_wdata, mem_wmask} !== {32'h0102_0304, 8'h0F}) begin
      errors++;
      $display("FAIL b2b_sw got %h %h exp 01020304 0f",
               mem_wdata, mem_wmask);
    end
    step();
    respond(32'h0);
    release_resp();
    issue(1'b1, 1'b0, 3'b000, 32'h8000_0010, 32'h0);
    checks++;
    if ({mem_req, mem_we, mem_wmask} !== 10'h200) begin
      errors++;
      $display("FAIL b2b_lb_req got %b%b %h exp 10 00",
               mem_req, mem_we, mem_wmask);
    end
    step();
    respond(32'h0102_0304);
    checks++;
    if (out_rdata !== 32'h0000_0004) begin
      errors++;
      $display("FAIL b2b_lb got %h exp 00000004", out_rdata);
    end
    release_resp();
  endtask

  task automatic test_reset_mid();
    logic [103:0] outs;
    issue(1'b1, 1'b0, 3'b010, 32'h8000_0020, 32'h0);
    step();
    #2 rst_n = 1'b0;
    #1;
    outs = {mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
            out_valid, out_rdata, out_err};
    checks++;
    if (outs !== '0) begin
      errors++;
      $display("FAIL rstmid_outs got %h exp 0", outs);
    end
    step();
    rst_n = 1'b1;
    mem_rsp_valid = 1'b1;
    mem_rsp_rdata = 32'h1234_5678;
    step();
    step();
    mem_rsp_valid = 1'b0;
    outs = {mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
            out_valid, out_rdata, out_err};
    checks++;
    if ({in_ready, outs} !== {1'b1, 104'h0}) begin
      errors++;
      $display("FAIL rstmid_drop got r%b %h exp r1 0", in_ready, outs);
    end
  endtask

  task automatic test_timeout();
    int n;
    n = 0;
    issue(1'b1, 1'b0, 3'b010, 32'h8000_0030, 32'h0);
    step();
    for (int i = 0; i < 300 && !out_valid; i++) begin
      step();
      n++;
    end
`ifdef YSYX_23060201_LSU_TIMEOUT_EN
    checks++;
    if (n !== 255) begin
      errors++;
      $display("FAIL to_cycles got %0d exp 255", n);
    end
    checks++;
    if ({out_valid, out_err, out_rdata} !== {2'b11, 32'h0}) begin
      errors++;
      $display("FAIL to_out got v%b e%b d%h exp 1 1 0",
               out_valid, out_err, out_rdata);
    end
    release_resp();
`else
    checks++;
    if (out_valid !== 1'b0 || n !== 300) begin
      errors++;
      $display("FAIL to_hold got v%b after %0d exp 0 after 300",
               out_valid, n);
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
`endif
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL to_idle got %b exp 1", in_ready);
    end
  endtask

  initial begin
    test_reset();
    test_store_byte();
    test_load_extend();
    test_errors();
    test_backpressure();
    test_rsp_ignored();
    test_back_to_back();
    test_reset_mid();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
